// File: rtl/alu_exec_seq.sv
// Sequencer around the combinational alu: accepts commands, drives alu inputs from
// registers, iterates into an accumulator and returns the result. Option: ALU_EXEC_ZFLAG_EN.
module alu_exec_seq #(
    parameter int size  = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [5:0]       cmd_sel,
    input  logic [size-1:0]  cmd_b,
    input  logic             cmd_cin,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_load,
    output logic [size-1:0]  alu_a,
    output logic [size-1:0]  alu_b,
    output logic             alu_cin,
    output logic [5:0]       alu_sel,
    input  logic [size-1:0]  alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [size-1:0]  res_data,
    output logic             res_err,
`ifdef ALU_EXEC_ZFLAG_EN
    output logic             res_zero,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q, state_d;
    logic [size-1:0]  acc_q, acc_d;
    logic [size-1:0]  b_q, b_d;
    logic [5:0]       sel_q, sel_d;
    logic             cin_q, cin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`ifdef ALU_EXEC_ZFLAG_EN
    logic             zero_q, zero_d;
`endif

    always_comb begin
        // NOTE: every register defaults to its held value first, so no path infers a latch.
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef ALU_EXEC_ZFLAG_EN
        zero_d  = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_d   = cmd_b;
                        err_d   = 1'b0;
                        state_d = DONE;
`ifdef ALU_EXEC_ZFLAG_EN
                        zero_d  = (cmd_b == '0);
`endif
                    end else if (cmd_sel[5:4] == 2'b01) begin
                        // Illegal shift code: report it without touching the accumulator.
                        err_d   = 1'b1;
                        state_d = DONE;
`ifdef ALU_EXEC_ZFLAG_EN
                        zero_d  = 1'b0;
`endif
                    end else begin
                        sel_d   = cmd_sel;
                        b_d     = cmd_b;
                        cin_d   = cmd_cin;
                        cnt_d   = cmd_cnt;
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                acc_d = alu_y;
                if (cnt_q == '0) begin
                    state_d = DONE;
`ifdef ALU_EXEC_ZFLAG_EN
                    zero_d  = (alu_y == '0);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cin_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef ALU_EXEC_ZFLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef ALU_EXEC_ZFLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = acc_q;
    assign res_err   = err_q;
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_cin   = cin_q;
    assign alu_sel   = sel_q;
`ifdef ALU_EXEC_ZFLAG_EN
    assign res_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Self-checking bench for alu_exec_seq: a behavioural alu stand-in drives alu_y,
// directed vectors from a table, reset corner cases, then randomized commands vs a model.
module tb_alu_exec_seq;

    typedef struct {
        logic       load;
        logic [5:0] sel;
        logic [7:0] b;
        logic       cin;
        logic [3:0] cnt;
    } cmd_t;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    typedef struct {
        cmd_t c;
        exp_t e;
        int   stall;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_cin, cmd_load;
    logic [5:0] cmd_sel;
    logic [7:0] cmd_b;
    logic [3:0] cmd_cnt;
    logic [7:0] alu_a, alu_b, alu_y, res_data;
    logic       alu_cin, res_valid, res_ready, res_err, busy;
    logic [5:0] alu_sel;
`ifdef ALU_EXEC_ZFLAG_EN
    logic       res_zero;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] model_acc = 8'h00;

    always #5 clk = ~clk;

    alu_exec_seq #(.size(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_cnt(cmd_cnt), .cmd_load(cmd_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err),
`ifdef ALU_EXEC_ZFLAG_EN
        .res_zero(res_zero),
`endif
        .busy(busy)
    );

    // Stand-in alu: arith/logic op, then a one-bit shift stage selected by sel[5:4].
    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic [5:0] sel);
        int         r;
        logic [7:0] t;
        if (sel[3]) begin
            case (sel[2:0])
                3'd0:    t = a & b;
                3'd1:    t = a | b;
                3'd2:    t = a ^ b;
                3'd3:    t = ~a;
                default: t = a;
            endcase
        end else begin
            case (sel[2:0])
                3'd0:    r = int'(a) + int'(cin);
                3'd1:    r = int'(a) - 1 + int'(cin);
                3'd2:    r = int'(a) + int'(b) + int'(cin);
                3'd3:    r = int'(a) + int'(~b) + int'(cin);
                3'd4:    r = int'(a) + int'(cin);
                3'd5:    r = int'(a) - 1;
                3'd6:    r = int'(a) + int'(b);
                default: r = int'(a) - int'(b);
            endcase
            t = r[7:0];
        end
        case (sel[5:4])
            2'b00:   return t >> 1;
            2'b11:   return t << 1;
            default: return t;
        endcase
    endfunction

    always_comb alu_y = ref_alu(alu_a, alu_b, alu_cin, alu_sel);

    // Command-level model: result, error flag and cycles from accept to res_valid.
    function automatic exp_t ref_cmd(input logic [7:0] acc, input cmd_t c);
        exp_t       e;
        logic [7:0] a;
        a = acc;
        if (c.load) begin
            e.data = c.b; e.err = 1'b0; e.lat = 1;
        end else if (c.sel[5:4] == 2'b01) begin
            e.data = acc; e.err = 1'b1; e.lat = 1;
        end else begin
            for (int i = 0; i <= int'(c.cnt); i++) a = ref_alu(a, c.b, c.cin, c.sel);
            e.data = a; e.err = 1'b0; e.lat = int'(c.cnt) + 2;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_cmd(input cmd_t c, input exp_t e, input int stall);
        int         lat;
        logic [7:0] held;
        logic       exec_cmd;
        exec_cmd = !c.load && (c.sel[5:4] != 2'b01);
        check("cmd_ready_idle", 32'(cmd_ready), 32'(1));
        cmd_valid = 1'b1; cmd_load = c.load; cmd_sel = c.sel;
        cmd_b = c.b; cmd_cin = c.cin; cmd_cnt = c.cnt;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 40) begin
            if (exec_cmd) begin
                check("alu_sel_stable", 32'(alu_sel), 32'(c.sel));
                check("alu_b_latched", 32'(alu_b), 32'(c.b));
                check("alu_cin_latched", 32'(alu_cin), 32'(c.cin));
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(e.lat));
        check("res_data", 32'(res_data), 32'(e.data));
        check("res_err", 32'(res_err), 32'(e.err));
        check("alu_a_is_acc", 32'(alu_a), 32'(e.data));
`ifdef ALU_EXEC_ZFLAG_EN
        check("res_zero", 32'(res_zero), 32'(!e.err && e.data == 8'h00));
`endif
        held = res_data;
        // A competing command offered during backpressure must be ignored.
        cmd_valid = (stall > 0); cmd_load = 1'b1; cmd_b = ~held;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(res_valid), 32'(1));
            check("stall_data", 32'(res_data), 32'(held));
            check("stall_err", 32'(res_err), 32'(e.err));
            check("stall_cmd_ready", 32'(cmd_ready), 32'(0));
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("release_valid", 32'(res_valid), 32'(0));
        check("release_cmd_ready", 32'(cmd_ready), 32'(1));
        model_acc = e.data;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
        check({tag, "_res_valid"}, 32'(res_valid), 32'(0));
        check({tag, "_res_err"}, 32'(res_err), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_res_data"}, 32'(res_data), 32'(0));
        check({tag, "_alu_a"}, 32'(alu_a), 32'(0));
        check({tag, "_alu_b"}, 32'(alu_b), 32'(0));
        check({tag, "_alu_sel"}, 32'(alu_sel), 32'(0));
        check({tag, "_alu_cin"}, 32'(alu_cin), 32'(0));
`ifdef ALU_EXEC_ZFLAG_EN
        check({tag, "_res_zero"}, 32'(res_zero), 32'(0));
`endif
    endtask

    vec_t vecs[10];

    initial begin
        cmd_t c;
        exp_t e;
        int   lat;

        vecs[0] = '{'{1'b1, 6'b10_0_000, 8'h05, 1'b0, 4'd0}, '{8'h05, 1'b0, 1}, 0};
        vecs[1] = '{'{1'b0, 6'b10_0_010, 8'h03, 1'b1, 4'd0}, '{8'h09, 1'b0, 2}, 0};
        vecs[2] = '{'{1'b0, 6'b11_0_000, 8'h00, 1'b0, 4'd2}, '{8'h48, 1'b0, 4}, 0};
        vecs[3] = '{'{1'b1, 6'b10_0_000, 8'hFF, 1'b0, 4'd0}, '{8'hFF, 1'b0, 1}, 0};
        vecs[4] = '{'{1'b0, 6'b10_0_110, 8'h02, 1'b0, 4'd0}, '{8'h01, 1'b0, 2}, 0};
        vecs[5] = '{'{1'b0, 6'b01_0_010, 8'h33, 1'b1, 4'd3}, '{8'h01, 1'b1, 1}, 5};
        vecs[6] = '{'{1'b0, 6'b10_1_010, 8'h0F, 1'b0, 4'd0}, '{8'h0E, 1'b0, 2}, 0};
        vecs[7] = '{'{1'b0, 6'b00_0_000, 8'h00, 1'b0, 4'd1}, '{8'h03, 1'b0, 3}, 5};
        vecs[8] = '{'{1'b1, 6'b10_0_000, 8'h00, 1'b0, 4'd0}, '{8'h00, 1'b0, 1}, 0};
        vecs[9] = '{'{1'b0, 6'b10_0_001, 8'h00, 1'b0, 4'd15}, '{8'hF0, 1'b0, 17}, 1};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_sel = '0;
        cmd_b = '0; cmd_cin = 1'b0; cmd_cnt = '0; res_ready = 1'b0;
        #12;
        check_reset_values("por");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_cmd(vecs[i].c, vecs[i].e, vecs[i].stall);

        // Reset dropped in the middle of a long EXEC sequence.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_sel = 6'b10_0_010;
        cmd_b = 8'h11; cmd_cin = 1'b0; cmd_cnt = 4'd7;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("mid_exec_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check_reset_values("exec_rst");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("exec_rst_ready_after", 32'(cmd_ready), 32'(1));
        model_acc = 8'h00;

        // Reset dropped while a result is waiting in DONE.
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 8'h5A;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_load = 1'b0;
        check("done_rst_valid_before", 32'(res_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("done_rst");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        model_acc = 8'h00;

        // Randomized commands against the command-level model.
        for (int n = 0; n < 60; n++) begin
            c.load = ($urandom_range(0, 4) == 0);
            c.sel  = 6'($urandom_range(0, 63));
            c.b    = 8'($urandom);
            c.cin  = 1'($urandom_range(0, 1));
            c.cnt  = 4'($urandom_range(0, 15));
            e = ref_cmd(model_acc, c);
            run_cmd(c, e, int'($urandom_range(0, 3)));
        end

        // Bounded drain: the block must be idle once the last result is taken.
        lat = 0;
        while (!cmd_ready && lat < 5) begin
            @(posedge clk); #1;
            lat++;
        end
        check("final_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
